// File: rtl/wb_xbar_pkg.sv
// Shared types and constants for the wb_xbar_n Wishbone 1-to-N interconnect.
// Region, slot width and the registered request bundle live here.
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic [11:0] WB_REGION_HI  = 12'hFFD;
    localparam int          WB_SLOT_W     = 4;
    localparam int          WB_MAX_SLAVES = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } req_t;

endpackage

// File: rtl/wb_xbar_timeout.sv
// Slave-stall watchdog: counts ACTIVE cycles and flags expiry at TIMEOUT_CYCLES-1.
// Latency: expire is combinational from the count; count restarts on start.
// Backpressure: none, it only observes the transfer.
module wb_xbar_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = active && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_xbar_n.sv
// Registered Wishbone 1-to-N interconnect for the 0xFFD0_0000 window, 64 kB per slot.
// Latency: request registered, slave stb one cycle later; ack/err pass through combinationally.
// Backpressure: one transfer in flight, new stb accepted only in IDLE; hung-slave timeout under WB_XBAR_TIMEOUT_EN.
module wb_xbar_n
    import wb_xbar_pkg::*;
#(
    parameter int N_SLAVES       = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              wb_adr,
    input  logic [31:0]              wb_dat_o,
    output logic [31:0]              wb_dat_i,
    input  logic                     wb_we,
    input  logic [3:0]               wb_sel,
    input  logic                     wb_stb,
    input  logic                     wb_cyc,
    output logic                     wb_ack,
    output logic                     wb_err,
    output logic [32*N_SLAVES-1:0]   wb_s_adr,
    output logic [32*N_SLAVES-1:0]   wb_s_dat_o,
    input  logic [32*N_SLAVES-1:0]   wb_s_dat_i,
    output logic [N_SLAVES-1:0]      wb_s_we,
    output logic [4*N_SLAVES-1:0]    wb_s_sel,
    output logic [N_SLAVES-1:0]      wb_s_stb,
    output logic [N_SLAVES-1:0]      wb_s_cyc,
    input  logic [N_SLAVES-1:0]      wb_s_ack,
    input  logic [N_SLAVES-1:0]      wb_s_err
);

    if (N_SLAVES < 1 || N_SLAVES > WB_MAX_SLAVES || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("wb_xbar_n: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [WB_SLOT_W-1:0] idx_q, idx_d;
    req_t                 req_q, req_d;
    logic                 first_q, first_d;

    logic        mapped;
    logic        enter_active;
    logic        expire;
    logic        sel_ack, sel_err;
    logic [31:0] sel_dat;

    assign mapped = (wb_adr[31:20] == WB_REGION_HI) &&
                    ({1'b0, wb_adr[19:16]} < 5'(N_SLAVES));
    assign enter_active = (state_q == IDLE) && wb_cyc && wb_stb && mapped;

`ifdef WB_XBAR_TIMEOUT_EN
    wb_xbar_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .start  (enter_active),
        .active (state_q == ACTIVE),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Slaves keep driving stale data; the latched index picks the one that matters.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == WB_SLOT_W'(i)) begin
                sel_ack = wb_s_ack[i];
                sel_err = wb_s_err[i];
                sel_dat = wb_s_dat_i[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        req_d    = req_q;
        first_d  = 1'b0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_i = '0;
        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    req_d.adr = wb_adr;
                    req_d.dat = wb_dat_o;
                    req_d.we  = wb_we;
                    req_d.sel = wb_sel;
                    if (mapped) begin
                        idx_d   = wb_adr[19:16];
                        first_d = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACTIVE: begin
                if (sel_ack) begin
                    wb_ack   = 1'b1;
                    wb_dat_i = sel_dat;
                    state_d  = IDLE;
                end else if (sel_err || expire) begin
                    wb_err  = 1'b1;
                    state_d = IDLE;
                end else if (!wb_cyc) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                wb_err  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_s_stb = '0;
        wb_s_cyc = '0;
        if (state_q == ACTIVE) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (idx_q == WB_SLOT_W'(i)) begin
                    wb_s_cyc[i] = ~expire;
                    wb_s_stb[i] = first_q;
                end
            end
        end
    end

    assign wb_s_adr   = {N_SLAVES{req_q.adr}};
    assign wb_s_dat_o = {N_SLAVES{req_q.dat}};
    assign wb_s_we    = {N_SLAVES{req_q.we}};
    assign wb_s_sel   = {N_SLAVES{req_q.sel}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            first_q <= first_d;
        end
    end

endmodule
